// File: rtl/hack_ram_param_pkg.sv
// Shared definitions for the parametrised Hack data RAM: word/depth defaults
// and the clear-engine state encoding.
package hack_ram_param_pkg;

  localparam int HACK_WORD_W       = 16;
  localparam int HACK_RAM16K_DEPTH = 16384;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_t;

endpackage

// File: rtl/hack_ram_param_core.sv
// Plain storage array: one synchronous write port, one asynchronous read port,
// no reset on contents.
module hack_ram_param_core #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16384,
  parameter int IDX_W  = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hack_ram_param.sv
// Parametrised Hack data RAM with selectable read latency, out-of-range guard
// and a zero-fill clear engine that sweeps every implemented word.
module hack_ram_param
  import hack_ram_param_pkg::*;
#(
  parameter int DATA_W         = HACK_WORD_W,
  parameter int ADDR_W         = 15,
  parameter int DEPTH          = HACK_RAM16K_DEPTH,
  parameter int READ_LATENCY   = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic              clear_req,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              oob,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              cpu_we;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rd_mux;

  assign busy = (state == ST_CLEAR);

  // One extra bit so DEPTH == 2**ADDR_W compares cleanly and never flags.
  assign oob = ({1'b0, address} >= (ADDR_W + 1)'(DEPTH));

  // A clear request in the same cycle as a CPU write takes priority.
  assign cpu_we = load && !busy && !oob && !clear_req;
  assign we     = busy || cpu_we;
  assign waddr  = busy ? clr_ptr[IDX_W-1:0] : address[IDX_W-1:0];
  assign wdata  = busy ? '0 : in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_ptr <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            err     <= 1'b0;
          end else if (load && oob) begin
            err <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_ptr == LAST_ADDR) state <= ST_IDLE;
          else clr_ptr <= clr_ptr + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hack_ram_param_core #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_core (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(address[IDX_W-1:0]),
    .rdata(rdata)
  );

  assign rd_mux = (busy || oob) ? '0 : rdata;

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign out = rd_mux;
    end else begin : g_reg_read
      logic [DATA_W-1:0] out_p1;
      // p0 -> p1: registered read, old contents returned on same-address write
      always_ff @(posedge clk or posedge reset) begin
        if (reset) out_p1 <= '0;
        else       out_p1 <= rd_mux;
      end
      assign out = out_p1;
    end
  endgenerate

endmodule

// File: tb/tb_hack_ram_param.sv
// Directed bench for hack_ram_param: a 16K combinational-read instance and a
// 24K registered-read instance, checked against a queue of expected values.
module tb_hack_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rst2;
  logic [14:0] address, address2;
  logic [15:0] din, din2;
  logic        load, load2, clear_req, clear_req2;
  logic [15:0] out, out2;
  logic        busy, busy2, oob, oob2, err, err2;

  hack_ram_param dut (
    .clk(clk), .reset(reset), .address(address), .in(din), .load(load),
    .clear_req(clear_req), .out(out), .busy(busy), .oob(oob), .err(err)
  );

  hack_ram_param #(
    .DATA_W(16), .ADDR_W(15), .DEPTH(24576), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut2 (
    .clk(clk), .reset(rst2), .address(address2), .in(din2), .load(load2),
    .clear_req(clear_req2), .out(out2), .busy(busy2), .oob(oob2), .err(err2)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: got %h, required a queued entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s: got %h, required %h", e.tag, obs, e.val);
    end
  endtask

  task automatic read1(input logic [14:0] a, input logic [15:0] expv, input string tag);
    @(negedge clk);
    address = a;
    load    = 1'b0;
    push(tag, {16'h0, expv});
    #1 pop_check({16'h0, out});
  endtask

  task automatic write1(input logic [14:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    din     = d;
    load    = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 40000) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask

  initial begin
    int cnt, c1, c2;
    reset = 1'b1; rst2 = 1'b1;
    address = '0; address2 = '0; din = '0; din2 = '0;
    load = 1'b0; load2 = 1'b0; clear_req = 1'b0; clear_req2 = 1'b0;

    #2;
    push("rst_busy", 1);   pop_check({31'h0, busy});
    push("rst_err", 0);    pop_check({31'h0, err});
    push("rst_out", 0);    pop_check({16'h0, out});
    push("rst_busy2", 1);  pop_check({31'h0, busy2});
    push("rst_out2", 0);   pop_check({16'h0, out2});

    // Power-up sweep on both instances
    @(negedge clk);
    reset = 1'b0; rst2 = 1'b0;
    cnt = 0; c1 = -1; c2 = -1;
    while ((busy || busy2) && cnt < 40000) begin
      @(posedge clk);
      #1 cnt++;
      if (!busy && c1 < 0) c1 = cnt;
      if (!busy2 && c2 < 0) c2 = cnt;
    end
    push("sweep_len", 16384);  pop_check(c1);
    push("sweep_len2", 24576); pop_check(c2);

    for (int n = 0; n < 10; n++) read1(15'(n), 16'h0000, "init_zero");

    for (int n = 0; n < 10; n++) write1(15'(n), 16'(n * 16'h1111));
    for (int n = 0; n < 10; n++) read1(15'(n), 16'(n * 16'h1111), "wr_rd");
    write1(15'h0000, 16'h5555);
    read1(15'h0000, 16'h5555, "overwrite");

    // Out-of-range access
    @(negedge clk);
    address = 15'h4000;
    #1;
    push("oob_flag", 1);  pop_check({31'h0, oob});
    push("oob_out", 0);   pop_check({16'h0, out});
    push("oob_err0", 0);  pop_check({31'h0, err});
    write1(15'h4000, 16'hFFFF);
    push("oob_err1", 1);  pop_check({31'h0, err});
    read1(15'h0000, 16'h5555, "oob_noalias");
    @(negedge clk);
    address = 15'h3FFF;
    #1 push("inrange_top", 0); pop_check({31'h0, oob});

    // Clear request with a simultaneous load
    @(negedge clk);
    address = 15'h0009; din = 16'hAAAA; load = 1'b1; clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0; load = 1'b0;
    push("clr_busy", 1);  pop_check({31'h0, busy});
    push("clr_err", 0);   pop_check({31'h0, err});
    push("clr_mask", 0);  pop_check({16'h0, out});
    cnt = 0;
    while (busy && cnt < 40000) begin
      @(posedge clk);
      #1 cnt++;
      if (cnt == 10) begin
        address = 15'h0003; din = 16'hBEEF; load = 1'b1;
      end else if (cnt == 11) begin
        load = 1'b0;
      end
    end
    push("clr_len", 16384); pop_check(cnt);
    for (int n = 0; n < 10; n++) read1(15'(n), 16'h0000, "clr_zero");

    // Reset in the middle of a sweep
    write1(15'h0007, 16'h7777);
    read1(15'h0007, 16'h7777, "post_clr_wr");
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    push("midrst_busy", 1); pop_check({31'h0, busy});
    @(negedge clk);
    reset = 1'b0;
    count_busy(cnt);
    push("midrst_len", 16384); pop_check(cnt);
    read1(15'h0007, 16'h0000, "midrst_zero");

    // Registered-read instance
    @(negedge clk);
    address2 = 15'h5FFF; din2 = 16'h1234; load2 = 1'b1;
    #1 push("t6_inrange", 0); pop_check({31'h0, oob2});
    @(posedge clk);
    #1;
    push("t6_old", 0); pop_check({16'h0, out2});
    load2 = 1'b0;
    @(posedge clk);
    #1 push("t6_new", 16'h1234); pop_check({16'h0, out2});
    @(negedge clk);
    address2 = 15'h6000;
    #1;
    push("t6_oob", 1);       pop_check({31'h0, oob2});
    push("t6_hold", 16'h1234); pop_check({16'h0, out2});
    @(posedge clk);
    #1;
    push("t6_oob_out", 0);   pop_check({16'h0, out2});
    push("t6_err", 0);       pop_check({31'h0, err2});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
